// File: rtl/cpu_pkg.sv
// Shared constants and types for the small CPU front end.
package cpu_pkg;

   localparam int ADDR_W  = 4;
   localparam int INSTR_W = 16;
   localparam int CNT_W   = 8;

   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LDI  = 4'b0110;
   localparam logic [3:0] OP_JMP  = 4'b0111;
   localparam logic [3:0] HALT_OP = 4'b1111;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: 4];
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, registers the fetched word toward decode,
// honours execute redirects and stops issuing after a HALT opcode.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | fetching; a word is issued whenever the output slot is free
//   ST_HALT | HALT word issued; no further fetch until redirect or rst
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int         P_ADDR_W  = ADDR_W,
   parameter int         P_INSTR_W = INSTR_W,
   parameter logic [3:0] P_HALT_OP = HALT_OP,
   parameter int         P_CNT_W   = CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [P_ADDR_W-1:0]  imem_addr,
   input  logic [P_INSTR_W-1:0] imem_instr,
   output logic                 if_valid,
   input  logic                 id_ready,
   output logic [P_INSTR_W-1:0] if_instr,
   output logic [P_ADDR_W-1:0]  if_pc,
   input  logic                 redirect_valid,
   input  logic [P_ADDR_W-1:0]  redirect_target,
   output logic                 halted,
   output logic [P_CNT_W-1:0]   fetch_count
);

   fetch_state_t        state;
   logic [P_ADDR_W-1:0] pc;
   logic [P_ADDR_W-1:0] pc_next;
   logic                issue;
   logic                is_halt_word;

   assign imem_addr    = pc;
   assign is_halt_word = (imem_instr[P_INSTR_W-1 -: 4] == P_HALT_OP);
   assign issue        = (state == ST_RUN) && !redirect_valid && (!if_valid || id_ready);

   always_comb begin
      pc_next = pc;
      if (rst)
         pc_next = '0;
      else if (redirect_valid)
         pc_next = redirect_target;
      else if (issue)
         pc_next = P_ADDR_W'(pc + 1'b1);
   end

   always_ff @(posedge clk) begin
      pc <= pc_next;
      if (rst) begin
         state       <= ST_RUN;
         if_valid    <= 1'b0;
         if_instr    <= '0;
         if_pc       <= '0;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else if (redirect_valid) begin
         // flush wins over a stalled decode and over a HALT word on the bus
         state    <= ST_RUN;
         halted   <= 1'b0;
         if_valid <= 1'b0;
      end else if (issue) begin
         if_instr <= imem_instr;
         if_pc    <= pc;
         if_valid <= 1'b1;
         if (fetch_count != '1)
            fetch_count <= fetch_count + 1'b1;
         if (is_halt_word) begin
            state  <= ST_HALT;
            halted <= 1'b1;
         end
      end else if (if_valid && id_ready) begin
         if_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized run
// against a transaction-level model of the fetch stage.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  imem_addr;
   logic [15:0] imem_instr;
   logic        if_valid;
   logic        id_ready;
   logic [15:0] if_instr;
   logic [3:0]  if_pc;
   logic        redirect_valid;
   logic [3:0]  redirect_target;
   logic        halted;
   logic [7:0]  fetch_count;

   logic [15:0] mem [16];
   int tests = 0;
   int fails = 0;

   // model state
   int          m_pc, m_ifpc, m_cnt;
   logic [15:0] m_instr;
   bit          m_valid, m_halt;

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_addr];

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .if_valid(if_valid), .id_ready(id_ready), .if_instr(if_instr), .if_pc(if_pc),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .halted(halted), .fetch_count(fetch_count)
   );

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: what the stage must do on each clock edge
   always @(posedge clk) begin
      if (rst) begin
         m_pc = 0; m_valid = 0; m_instr = 0; m_ifpc = 0; m_halt = 0; m_cnt = 0;
      end else if (redirect_valid) begin
         m_pc = redirect_target; m_valid = 0; m_halt = 0;
      end else if (!m_halt && (!m_valid || id_ready)) begin
         m_instr = mem[m_pc];
         m_ifpc  = m_pc;
         m_valid = 1;
         m_pc    = (m_pc + 1) % 16;
         if (m_cnt < 255) m_cnt = m_cnt + 1;
         if (m_instr[15:12] == 4'hF) m_halt = 1;
      end else if (m_valid && id_ready) begin
         m_valid = 0;
      end
   end

   bit checking = 0;
   always @(negedge clk) begin
      if (checking) begin
         chk("imem_addr", imem_addr, m_pc);
         chk("if_valid", if_valid, m_valid);
         chk("halted", halted, m_halt);
         chk("fetch_count", fetch_count, m_cnt);
         if (m_valid) begin
            chk("if_pc", if_pc, m_ifpc);
            chk("if_instr", if_instr, m_instr);
         end
      end
   end

   task automatic step(input bit rdy, input bit rv, input logic [3:0] tgt);
      id_ready = rdy; redirect_valid = rv; redirect_target = tgt;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1; id_ready = 0; redirect_valid = 0; redirect_target = 0;
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom) & 16'hEFFF;
      mem[0] = 16'h7016; mem[1] = 16'h6516; mem[2] = 16'h1045; mem[3] = 16'h6057;
      mem[4] = 16'hF000;
      @(posedge clk); @(posedge clk); #1;
      checking = 1;
      chk("rst if_valid", if_valid, 0);
      chk("rst fetch_count", fetch_count, 0);
      chk("rst halted", halted, 0);
      chk("rst imem_addr", imem_addr, 0);
      chk("rst if_pc", if_pc, 0);
      chk("rst if_instr", if_instr, 0);
      rst = 0;

      // program fetch
      step(1, 0, 0); chk("f0 pc", if_pc, 0); chk("f0 instr", if_instr, 16'h7016);
      step(1, 0, 0); chk("f1 pc", if_pc, 1); chk("f1 instr", if_instr, 16'h6516);
      step(1, 0, 0); chk("f2 pc", if_pc, 2); chk("f2 instr", if_instr, 16'h1045);
      // backpressure while if_pc = 2
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0);
         chk("bp instr", if_instr, 16'h1045); chk("bp pc", if_pc, 2);
         chk("bp addr", imem_addr, 3); chk("bp count", fetch_count, 3);
      end
      step(1, 0, 0); chk("f3 pc", if_pc, 3); chk("f3 instr", if_instr, 16'h6057);
      chk("f3 count", fetch_count, 4);
      // halt word at 4
      step(1, 0, 0); chk("halt pc", if_pc, 4); chk("halt instr", if_instr, 16'hF000);
      chk("halt flag", halted, 1);
      step(1, 0, 0); chk("halt drain", if_valid, 0);
      step(1, 0, 0); step(1, 0, 0);
      chk("halt idle", if_valid, 0); chk("halt count", fetch_count, 5);
      step(1, 1, 0); chk("resume halted", halted, 0); chk("resume addr", imem_addr, 0);
      step(1, 0, 0); chk("resume pc", if_pc, 0); chk("resume valid", if_valid, 1);
      // redirect with stalled decode
      step(0, 1, 9); chk("redir flush", if_valid, 0); chk("redir addr", imem_addr, 9);
      step(1, 0, 0); chk("redir pc", if_pc, 9);
      // wrap-around
      step(1, 1, 13);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0); chk("wrap pc", if_pc, (13 + i) % 16);
      end
      // reset mid-transfer
      step(0, 0, 0); chk("pre-rst valid", if_valid, 1);
      rst = 1; step(0, 0, 0); rst = 0;
      chk("mrst valid", if_valid, 0); chk("mrst addr", imem_addr, 0);
      chk("mrst count", fetch_count, 0); chk("mrst halted", halted, 0);

      // randomized run; occasional halt words, redirects and resets
      for (int i = 0; i < 16; i++)
         mem[i] = ($urandom_range(0, 9) == 0) ? 16'hF000 | 16'($urandom_range(0, 4095))
                                               : 16'($urandom) & 16'hEFFF;
      for (int c = 0; c < 3000; c++) begin
         rst = (c % 1000 == 999);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, 4'($urandom));
      end
      rst = 0;
      // long redirect-free, halt-free stretch to reach counter saturation
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom) & 16'hEFFF;
      step(1, 1, 0);
      for (int c = 0; c < 300; c++) step(1, 0, 0);
      chk("saturate", fetch_count, 255);

      checking = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the 16 x 16-bit combinational instruction memory.
- Owns the program counter and drives the memory address each cycle.
- Captures the returned word into a registered fetch/decode output with a valid/ready handshake toward decode.
- Handles branch redirects from execute and stops fetching on a HALT opcode.

Parameters:
- ADDR_W, 4, PC / instruction-memory address width (16 words).
- INSTR_W, 16, instruction width.
- HALT_OP, 4'b1111, opcode (instr[15:12]) that stops fetching.
- CNT_W, 8, width of the issued-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  ADDR_W  address to instruction memory; combinationally equal to pc.
- imem_instr  input  INSTR_W  instruction word returned combinationally for imem_addr.
- if_valid  output  1  if_instr/if_pc hold a valid instruction for decode.
- id_ready  input  1  decode accepts the instruction this cycle.
- if_instr  output  INSTR_W  registered instruction.
- if_pc  output  ADDR_W  address if_instr was fetched from.
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_target  input  ADDR_W  new fetch address.
- halted  output  1  high while state = HALT.
- fetch_count  output  CNT_W  number of issued instructions, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: pc = 0, state = RUN, if_valid = 0, if_instr = 0, if_pc = 0, halted = 0, fetch_count = 0.
- rst has priority over all other inputs, including when asserted mid-transfer with if_valid = 1.
- States:
  - RUN: fetching.
  - HALT: no fetch. halted = (state == HALT).
- Issue condition: issue = (state == RUN) && !redirect_valid && (!if_valid || id_ready).
- On issue, at the clock edge:
  - if_instr <= imem_instr, if_pc <= pc, if_valid <= 1.
  - pc <= pc + 1, wrapping modulo 2^ADDR_W (15 -> 0).
  - fetch_count increments and saturates at all-ones.
- Latency: one cycle from pc to if_instr.
- Backpressure: if if_valid && !id_ready, then if_instr, if_pc, if_valid and pc hold unchanged.
- Drain: if if_valid && id_ready && !issue (HALT state or redirect), if_valid <= 0.
- Redirect (any state, when not in reset):
  - pc <= redirect_target, if_valid <= 0 (flush, even if decode is stalled), state <= RUN.
  - No issue that cycle; the first instruction at the target appears one cycle later.
- HALT entry: on issuing a word with imem_instr[15:12] == HALT_OP:
  - The HALT word itself is issued to decode.
  - pc advances, state <= HALT.
  - The outstanding word is delivered normally under the handshake; no further issue.
- HALT exit: only by redirect or rst.
- Simultaneous redirect and HALT-opcode fetch: redirect wins and state stays RUN.

Decomposition:
- Shared package `cpu_pkg`:
  - ADDR_W and INSTR_W constants.
  - Opcode localparams, including HALT_OP = 4'b1111.
  - Fetch state enum {RUN, HALT}.
- Single module; no sub-module is warranted.
- The PC next-value mux (reset / redirect / increment / hold) is an internal always block.

Test Plan:
- Program fetch: memory words 0..3 = 16'h7016, 16'h6516, 16'h1045, 16'h6057; id_ready = 1; rst released.
  -> Clocks 1..4 give (if_pc, if_instr) = (0, 7016), (1, 6516), (2, 1045), (3, 6057).
  -> fetch_count = 4; if_valid = 0 only in the first cycle after reset.
- Backpressure: id_ready = 0 for 3 cycles while if_pc = 2.
  -> if_instr = 16'h1045 stable; imem_addr holds 3; fetch_count unchanged.
  -> After id_ready = 1, next if_pc = 3.
- Redirect: redirect_valid = 1, redirect_target = 9 with if_valid = 1 and id_ready = 0.
  -> Next cycle if_valid = 0 and imem_addr = 9.
  -> Following cycle if_pc = 9.
- Wrap-around: run from pc 13 with id_ready = 1.
  -> if_pc sequence is 13, 14, 15, 0, 1.
- Halt: word 4 = 16'hF000.
  -> if_pc = 4 is issued; halted = 1 from the next cycle; no further valid words after it is consumed.
  -> redirect_target = 0 resumes with if_pc = 0 and halted = 0.
- Reset mid-operation: rst asserted with if_valid = 1 and id_ready = 0.
  -> Next edge: if_valid = 0, pc = 0, fetch_count = 0, halted = 0.
